// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM encodings and width limits for serial_subtractor
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Bit counter needs at least one bit even when WIDTH is 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// rtl/serial_subtractor_half_subtractor.sv - gate-level half subtractor cell
module half_subtractor (
  input  logic A,
  input  logic B,
  output logic Diff,
  output logic Borrow
);

  assign Diff   = A ^ B;
  assign Borrow = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned A-B, LSB first, start/done handshake
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;

  logic             w_d0;
  logic             w_b0;
  logic             w_d;
  logic             w_b1;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Two half subtractors plus an OR form the per-bit full subtractor.
  half_subtractor u_hs0 (
    .A      (r_sa[0]),
    .B      (r_sb[0]),
    .Diff   (w_d0),
    .Borrow (w_b0)
  );

  half_subtractor u_hs1 (
    .A      (w_d0),
    .B      (r_bin),
    .Diff   (w_d),
    .Borrow (w_b1)
  );

  assign w_bout     = w_b0 | w_b1;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_res_next = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_bin   <= 1'b0;
      r_cnt   <= '0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_res <= '0;
            r_bin <= 1'b0;
            r_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_res <= w_res_next;
          r_bin <= w_bout;
          // Outputs only change on the final bit so partial results never show.
          if (w_last) begin
            diff   <= w_res_next;
            borrow <= w_bout;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH 4, 1, 8) and half_subtractor
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st[3];
  logic [31:0] av[3];
  logic [31:0] bv[3];
  logic        busy_w[3];
  logic        done_w[3];
  logic        brw_w[3];
  logic [3:0]  d4;
  logic [0:0]  d1;
  logic [7:0]  d8;

  int n_checks = 0;
  int n_errors = 0;
  int e;

  int          phase[3];
  logic [31:0] pend_d[3];
  logic        pend_b[3];
  logic [31:0] exp_d[3];
  logic        exp_b[3];

  logic hs_a, hs_b, hs_d, hs_bo;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st[0]), .a(av[0][3:0]), .b(bv[0][3:0]),
    .busy(busy_w[0]), .done(done_w[0]), .diff(d4), .borrow(brw_w[0]));

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .a(av[1][0:0]), .b(bv[1][0:0]),
    .busy(busy_w[1]), .done(done_w[1]), .diff(d1), .borrow(brw_w[1]));

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st[2]), .a(av[2][7:0]), .b(bv[2][7:0]),
    .busy(busy_w[2]), .done(done_w[2]), .diff(d8), .borrow(brw_w[2]));

  half_subtractor u_hs (.A(hs_a), .B(hs_b), .Diff(hs_d), .Borrow(hs_bo));

  function automatic int wid(input int j);
    case (j)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] mask(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] get_diff(input int j);
    case (j)
      0:       return {28'd0, d4};
      1:       return {31'd0, d1};
      default: return {24'd0, d8};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: phase k = number of edges since acceptance; result is plain modular subtraction.
  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        phase[j] <= 0;
        exp_d[j] <= '0;
        exp_b[j] <= 1'b0;
      end else if (phase[j] == 0) begin
        if (st[j]) begin
          phase[j]  <= 1;
          pend_d[j] <= (av[j] - bv[j]) & mask(wid(j));
          pend_b[j] <= (av[j] & mask(wid(j))) < (bv[j] & mask(wid(j)));
        end
      end else if (phase[j] <= wid(j)) begin
        phase[j] <= phase[j] + 1;
        if (phase[j] == wid(j)) begin
          exp_d[j] <= pend_d[j];
          exp_b[j] <= pend_b[j];
        end
      end else begin
        phase[j] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("dut%0d busy", j), {31'd0, busy_w[j]},
          {31'd0, (phase[j] >= 1 && phase[j] <= wid(j))});
      chk($sformatf("dut%0d done", j), {31'd0, done_w[j]}, {31'd0, (phase[j] == wid(j) + 1)});
      chk($sformatf("dut%0d diff", j), get_diff(j), exp_d[j]);
      chk($sformatf("dut%0d borrow", j), {31'd0, brw_w[j]}, {31'd0, exp_b[j]});
    end
  end

  task automatic wait_done(input int j, input string nm);
    e = 0;
    while (!done_w[j] && e < 40) begin
      @(negedge clk);
      e++;
    end
    chk({nm, " latency"}, e, wid(j));
  endtask

  task automatic run_op(input int j, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] xd, input logic xb, input string nm);
    @(negedge clk);
    st[j] = 1'b1;
    av[j] = a;
    bv[j] = b;
    @(negedge clk);
    st[j] = 1'b0;
    av[j] = $urandom;
    bv[j] = $urandom;
    wait_done(j, nm);
    chk({nm, " diff"}, get_diff(j), xd);
    chk({nm, " borrow"}, {31'd0, brw_w[j]}, {31'd0, xb});
  endtask

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] hs_dt;
    logic [3:0] hs_bt;
    logic [7:0] ra, rb;
    for (int j = 0; j < 3; j++) begin
      st[j] = 1'b0;
      av[j] = '0;
      bv[j] = '0;
    end
    hs_a = 1'b0;
    hs_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy_w[0]}, 32'd0);
    chk("reset done", {31'd0, done_w[0]}, 32'd0);
    chk("reset diff", get_diff(0), 32'd0);
    chk("reset borrow", {31'd0, brw_w[0]}, 32'd0);
    rst = 1'b0;

    hs_dt = 4'b0110;
    hs_bt = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      hs_a = i[1];
      hs_b = i[0];
      #1;
      chk($sformatf("hs diff %0d", i), {31'd0, hs_d}, {31'd0, hs_dt[i]});
      chk($sformatf("hs borrow %0d", i), {31'd0, hs_bo}, {31'd0, hs_bt[i]});
    end

    run_op(0, 9, 3, 6, 1'b0, "w4 9-3");
    run_op(0, 3, 9, 10, 1'b1, "w4 3-9");
    run_op(0, 0, 0, 0, 1'b0, "w4 0-0");
    run_op(0, 15, 15, 0, 1'b0, "w4 15-15");
    run_op(0, 0, 1, 15, 1'b1, "w4 0-1");

    // Asynchronous reset mid-operation, outputs holding a nonzero previous result.
    @(negedge clk);
    st[0] = 1'b1;
    av[0] = 9;
    bv[0] = 3;
    @(negedge clk);
    st[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async busy", {31'd0, busy_w[0]}, 32'd0);
    chk("async done", {31'd0, done_w[0]}, 32'd0);
    chk("async diff", get_diff(0), 32'd0);
    chk("async borrow", {31'd0, brw_w[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(0, 5, 2, 3, 1'b0, "w4 after rst");

    // Start held high with inputs changing during SHIFT.
    @(negedge clk);
    st[0] = 1'b1;
    av[0] = 12;
    bv[0] = 5;
    @(negedge clk);
    av[0] = 1;
    bv[0] = 1;
    wait_done(0, "hold 12-5");
    chk("hold 12-5 diff", get_diff(0), 7);
    chk("hold 12-5 borrow", {31'd0, brw_w[0]}, 32'd0);
    @(negedge clk);
    chk("hold idle busy", {31'd0, busy_w[0]}, 32'd0);
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, "hold 1-1");
    chk("hold 1-1 diff", get_diff(0), 0);
    chk("hold 1-1 borrow", {31'd0, brw_w[0]}, 32'd0);

    run_op(1, 0, 0, 0, 1'b0, "w1 0-0");
    run_op(1, 0, 1, 1, 1'b1, "w1 0-1");
    run_op(1, 1, 0, 1, 1'b0, "w1 1-0");
    run_op(1, 1, 1, 0, 1'b0, "w1 1-1");

    run_op(2, 8'd200, 8'd55, 8'd145, 1'b0, "w8 200-55");
    run_op(2, 8'd1, 8'd2, 8'd255, 1'b1, "w8 1-2");
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(2, {24'd0, ra}, {24'd0, rb}, {24'd0, ra - rb}, ra < rb, "w8 rnd");
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
